// File: rtl/ddr_init_sequencer.sv
// DDR SDRAM power-up init sequencer with periodic auto-refresh request timer.
// Runs the JEDEC init command sequence after clock lock, then raises init_done
// and requests auto-refresh every T_REFI cycles via a req/ack handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | idle until the DDR clock reports lock
// STABLE    | CKE low, NOP for T_STABLE cycles
// CKE_ON    | CKE raised, one NOP cycle
// PRE1      | PRECHARGE all issued, waiting T_RP
// EMR       | LOAD MODE (extended) issued, waiting T_MRD
// MR_DLL    | LOAD MODE with DLL reset issued, waiting T_MRD
// PRE2      | PRECHARGE all issued, waiting T_RP
// REF1      | AUTO REFRESH issued, waiting T_RFC
// REF2      | AUTO REFRESH issued, waiting T_RFC
// MR        | final LOAD MODE issued (one cycle)
// DLL_WAIT  | NOP for T_DLL cycles; covers the MRD gap after the final MR
// DONE      | init complete, refresh timer running
module ddr_init_sequencer #(
  parameter int unsigned T_STABLE  = 20000,
  parameter int unsigned T_RP      = 2,
  parameter int unsigned T_MRD     = 2,
  parameter int unsigned T_RFC     = 8,
  parameter int unsigned T_DLL     = 200,
  parameter int unsigned T_REFI    = 780,
  parameter logic [12:0] MODE_REG  = 13'h021,
  parameter logic [12:0] EMODE_REG = 13'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_ok,
  output logic        ddr_cke,
  output logic [3:0]  ddr_cmd,
  output logic [1:0]  ddr_ba,
  output logic [12:0] ddr_addr,
  output logic        init_done,
  output logic        refresh_req,
  input  logic        refresh_ack,
  output logic        refresh_overrun
);

  localparam logic [3:0]  CMD_NOP  = 4'b0111;
  localparam logic [3:0]  CMD_PRE  = 4'b0010;
  localparam logic [3:0]  CMD_REF  = 4'b0001;
  localparam logic [3:0]  CMD_LMR  = 4'b0000;
  localparam logic [12:0] ADDR_ALL_BANKS = 13'h400;
  localparam logic [12:0] DLL_RESET_BIT  = 13'h100;

  localparam int unsigned MAX_A   = (T_STABLE > T_DLL) ? T_STABLE : T_DLL;
  localparam int unsigned MAX_B   = (T_RP > T_MRD) ? T_RP : T_MRD;
  localparam int unsigned MAX_C   = (MAX_B > T_RFC) ? MAX_B : T_RFC;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int REF_W = (T_REFI > 2) ? $clog2(T_REFI) : 1;

  typedef enum logic [3:0] {
    WAIT_LOCK, STABLE, CKE_ON, PRE1, EMR, MR_DLL,
    PRE2, REF1, REF2, MR, DLL_WAIT, DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               cnt_zero;
  logic [3:0]         cmd_nxt;
  logic [1:0]         ba_nxt;
  logic [12:0]        addr_nxt;
  logic               cke_nxt;
  logic               done_nxt;
  logic [REF_W-1:0]   ref_cnt;
  logic               ref_wrap;

  assign cnt_zero = (cnt == '0);
  assign ref_wrap = (ref_cnt == REF_W'(T_REFI - 1));

  // Next state, dwell counter reload and the command issued on entry to a state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cmd_nxt   = CMD_NOP;
    ba_nxt    = 2'b00;
    addr_nxt  = '0;
    if (!clk_ok) begin
      state_nxt = WAIT_LOCK;
      cnt_nxt   = '0;
    end else begin
      if (!cnt_zero) cnt_nxt = cnt - CNT_W'(1);
      case (state)
        WAIT_LOCK: begin
          state_nxt = STABLE;
          cnt_nxt   = CNT_W'(T_STABLE - 1);
        end
        STABLE: if (cnt_zero) begin
          state_nxt = CKE_ON;
          cnt_nxt   = '0;
        end
        CKE_ON: if (cnt_zero) begin
          state_nxt = PRE1;
          cnt_nxt   = CNT_W'(T_RP - 1);
          cmd_nxt   = CMD_PRE;
          addr_nxt  = ADDR_ALL_BANKS;
        end
        PRE1: if (cnt_zero) begin
          state_nxt = EMR;
          cnt_nxt   = CNT_W'(T_MRD - 1);
          cmd_nxt   = CMD_LMR;
          ba_nxt    = 2'b01;
          addr_nxt  = EMODE_REG;
        end
        EMR: if (cnt_zero) begin
          state_nxt = MR_DLL;
          cnt_nxt   = CNT_W'(T_MRD - 1);
          cmd_nxt   = CMD_LMR;
          addr_nxt  = MODE_REG | DLL_RESET_BIT;
        end
        MR_DLL: if (cnt_zero) begin
          state_nxt = PRE2;
          cnt_nxt   = CNT_W'(T_RP - 1);
          cmd_nxt   = CMD_PRE;
          addr_nxt  = ADDR_ALL_BANKS;
        end
        PRE2: if (cnt_zero) begin
          state_nxt = REF1;
          cnt_nxt   = CNT_W'(T_RFC - 1);
          cmd_nxt   = CMD_REF;
        end
        REF1: if (cnt_zero) begin
          state_nxt = REF2;
          cnt_nxt   = CNT_W'(T_RFC - 1);
          cmd_nxt   = CMD_REF;
        end
        REF2: if (cnt_zero) begin
          state_nxt = MR;
          cnt_nxt   = '0;
          cmd_nxt   = CMD_LMR;
          addr_nxt  = MODE_REG & ~DLL_RESET_BIT;
        end
        MR: if (cnt_zero) begin
          state_nxt = DLL_WAIT;
          cnt_nxt   = CNT_W'(T_DLL - 1);
        end
        DLL_WAIT: if (cnt_zero) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end
        DONE: cnt_nxt = '0;
        default: begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      endcase
    end
    cke_nxt  = (state_nxt != WAIT_LOCK) && (state_nxt != STABLE);
    done_nxt = (state_nxt == DONE);
  end

  // State and dwell counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered command bus and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ddr_cke   <= 1'b0;
      ddr_cmd   <= CMD_NOP;
      ddr_ba    <= 2'b00;
      ddr_addr  <= '0;
      init_done <= 1'b0;
    end else begin
      ddr_cke   <= cke_nxt;
      ddr_cmd   <= cmd_nxt;
      ddr_ba    <= ba_nxt;
      ddr_addr  <= addr_nxt;
      init_done <= done_nxt;
    end
  end

  // Refresh interval timer with req/ack handshake; overrun survives clock loss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt         <= '0;
      refresh_req     <= 1'b0;
      refresh_overrun <= 1'b0;
    end else if (!clk_ok || state != DONE) begin
      ref_cnt     <= '0;
      refresh_req <= 1'b0;
    end else if (ref_wrap) begin
      ref_cnt     <= '0;
      refresh_req <= 1'b1;
      if (refresh_req && !refresh_ack) refresh_overrun <= 1'b1;
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
      if (refresh_ack) refresh_req <= 1'b0;
    end
  end

endmodule
